// File: rtl/debug_dump_tx.sv
// Debug dump transmitter: streams HDR, PC, register file and data memory as one
// MSB-first byte frame into the UART TX FIFO, stalling on FIFO-full.
module debug_dump_tx #(
  parameter int          NB_REG      = 32,
  parameter int          N_REGS      = 32,
  parameter int          N_MEM_WORDS = 32,
  parameter logic [7:0]  HDR_BYTE    = 8'hA5
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [NB_REG-1:0] i_pc,
  input  logic [NB_REG-1:0] i_reg_data,
  input  logic [NB_REG-1:0] i_mem_data,
  input  logic              i_tx_full,
  output logic [NB_REG-1:0] o_addr,
  output logic              o_sel,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_wr,
  output logic              o_busy,
  output logic              o_done
);

  // state   | meaning
  // IDLE    | waiting for i_start; PC snapshot taken on start
  // HDR     | send header byte
  // PC      | send the four PC bytes
  // FETCH   | present o_addr for the current word
  // LATCH   | capture read data into the shift register
  // WORD    | send the four bytes of the current word
  // DONE    | one-cycle o_done pulse

  localparam int N_MAX    = (N_REGS > N_MEM_WORDS) ? N_REGS : N_MEM_WORDS;
  localparam int NB_IDX   = (N_MAX > 1) ? $clog2(N_MAX) : 1;
  localparam int NB_BYTES = NB_REG / 8;
  localparam int NB_BCNT  = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_PC, S_FETCH, S_LATCH, S_WORD, S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [NB_REG-1:0]   r_shift;
  logic [NB_BCNT-1:0]  r_bcnt;
  logic [NB_IDX-1:0]   r_idx;
  logic                r_sel;
  logic                w_tx_wr;
  logic                w_last_byte;
  logic                w_last_idx;

  assign w_last_byte = (r_bcnt == '0);
  assign w_last_idx  = r_sel ? (r_idx == NB_IDX'(N_MEM_WORDS - 1))
                             : (r_idx == NB_IDX'(N_REGS - 1));

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tx_wr     = 1'b0;
    o_tx_data   = 8'h00;
    o_done      = 1'b0;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_HDR;
      S_HDR: begin
        w_tx_wr   = ~i_tx_full;
        o_tx_data = HDR_BYTE;
        if (!i_tx_full) w_state_nxt = S_PC;
      end
      S_PC: begin
        w_tx_wr   = ~i_tx_full;
        o_tx_data = r_shift[NB_REG-1 -: 8];
        if (!i_tx_full && w_last_byte) w_state_nxt = S_FETCH;
      end
      S_FETCH: w_state_nxt = S_LATCH;
      S_LATCH: w_state_nxt = S_WORD;
      S_WORD: begin
        w_tx_wr   = ~i_tx_full;
        o_tx_data = r_shift[NB_REG-1 -: 8];
        if (!i_tx_full && w_last_byte)
          w_state_nxt = (r_sel && w_last_idx) ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Byte counter is a down-counter; terminal count 0 marks the last byte of a word.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_shift <= '0;
      r_bcnt  <= NB_BCNT'(NB_BYTES - 1);
      r_idx   <= '0;
      r_sel   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_shift <= i_pc;
            r_bcnt  <= NB_BCNT'(NB_BYTES - 1);
            r_idx   <= '0;
            r_sel   <= 1'b0;
          end
        end
        S_PC: begin
          if (w_tx_wr) begin
            r_shift <= {r_shift[NB_REG-9:0], 8'h00};
            r_bcnt  <= r_bcnt - NB_BCNT'(1);
          end
        end
        S_LATCH: begin
          r_shift <= r_sel ? i_mem_data : i_reg_data;
          r_bcnt  <= NB_BCNT'(NB_BYTES - 1);
        end
        S_WORD: begin
          if (w_tx_wr) begin
            r_shift <= {r_shift[NB_REG-9:0], 8'h00};
            r_bcnt  <= r_bcnt - NB_BCNT'(1);
            if (w_last_byte) begin
              // End of section: restart index; after memory this returns sel to 0.
              if (w_last_idx) begin
                r_idx <= '0;
                r_sel <= ~r_sel;
              end else begin
                r_idx <= r_idx + NB_IDX'(1);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_tx_wr = w_tx_wr;
  assign o_busy  = (r_state != S_IDLE);
  assign o_sel   = r_sel;
  assign o_addr  = {{(NB_REG-NB_IDX){1'b0}}, r_idx};

endmodule

// File: tb/tb_debug_dump_tx.sv
// Testbench for debug_dump_tx: per-cycle schedule model plus expected byte stream.
module tb_debug_dump_tx;
  localparam int NW     = 32;
  localparam int SLOTS  = 390;
  localparam int NBYTES = 261;
  localparam int MAXC   = 1000;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_start = 1'b0;
  logic        i_tx_full = 1'b0;
  logic [31:0] i_pc = '0;
  logic [31:0] i_reg_data = '0;
  logic [31:0] i_mem_data = '0;
  logic [31:0] o_addr;
  logic        o_sel;
  logic [7:0]  o_tx_data;
  logic        o_tx_wr;
  logic        o_busy;
  logic        o_done;

  debug_dump_tx dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_pc(i_pc),
    .i_reg_data(i_reg_data), .i_mem_data(i_mem_data), .i_tx_full(i_tx_full),
    .o_addr(o_addr), .o_sel(o_sel), .o_tx_data(o_tx_data), .o_tx_wr(o_tx_wr),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  logic [31:0] regs [NW];
  logic [31:0] mems [NW];

  always @(posedge i_clk) begin
    i_reg_data <= regs[o_addr[4:0]];
    i_mem_data <= mems[o_addr[4:0]];
  end

  int total = 0;
  int bad   = 0;

  // stimulus configuration
  bit          full_pat [MAXC];
  int          start2_at;
  int          rst_at;
  int          pc_chg_at;
  bit          start_on_done;
  logic [31:0] pc_val;

  // recorded trace
  logic        tr_wr   [MAXC];
  logic [7:0]  tr_data [MAXC];
  logic        tr_busy [MAXC];
  logic        tr_done [MAXC];
  logic [31:0] tr_addr [MAXC];
  logic        tr_sel  [MAXC];
  logic [7:0]  got [$];

  // reference model
  int          ex_slot [MAXC];
  bit          ex_wr   [MAXC];
  bit          ex_busy [MAXC];
  bit          ex_done [MAXC];
  int          ex_end;
  int          ex_stalls;
  logic [7:0]  ex_bytes [NBYTES];

  // Frame timeline in slots: 0 header, 1-4 PC, then per word 2 address slots
  // followed by 4 byte slots, final slot 389 is the done pulse.
  function automatic bit is_send(int p);
    return (p >= 0 && p <= 4) || (p >= 5 && p < SLOTS - 1 && ((p - 5) % 6) >= 2);
  endfunction

  function automatic int byte_of_slot(int p);
    if (p <= 4) return p;
    return 5 + 4 * ((p - 5) / 6) + ((p - 5) % 6) - 2;
  endfunction

  task automatic build_expect(input int ncyc);
    int p;
    p = -1;
    ex_end = -1;
    ex_stalls = 0;
    for (int c = 0; c < ncyc; c++) begin
      ex_slot[c] = -1; ex_wr[c] = 1'b0; ex_busy[c] = 1'b0; ex_done[c] = 1'b0;
      if (p >= 0 && p < SLOTS) begin
        ex_slot[c] = p;
        ex_busy[c] = 1'b1;
        ex_done[c] = (p == SLOTS - 1);
        if (ex_done[c]) ex_end = c;
        if (is_send(p) && full_pat[c]) ex_stalls++;
        else begin
          ex_wr[c] = is_send(p);
          p++;
        end
      end
      if (c == 0) p = 0;
    end
  endtask

  task automatic build_bytes(input logic [31:0] pc);
    logic [31:0] w;
    ex_bytes[0] = 8'hA5;
    for (int b = 0; b < 4; b++) ex_bytes[1 + b] = pc[31 - 8 * b -: 8];
    for (int k = 0; k < 2 * NW; k++) begin
      w = (k < NW) ? regs[k] : mems[k - NW];
      for (int b = 0; b < 4; b++) ex_bytes[5 + 4 * k + b] = w[31 - 8 * b -: 8];
    end
  endtask

  task automatic clear_cfg();
    for (int c = 0; c < MAXC; c++) full_pat[c] = 1'b0;
    start2_at = -1; rst_at = -1; pc_chg_at = -1; start_on_done = 1'b0;
  endtask

  task automatic rand_data();
    for (int i = 0; i < NW; i++) begin
      regs[i] = $urandom;
      mems[i] = $urandom;
    end
  endtask

  task automatic fixed_data();
    for (int i = 0; i < NW; i++) begin
      regs[i] = i * 32'h0101_0101;
      mems[i] = 32'hDEAD_0000 + i;
    end
  endtask

  // Cycle 0 is the i_start cycle; inputs are driven at the falling edge and
  // outputs sampled 1 time unit later.
  task automatic drive_frame(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge i_clk);
      i_start   = (c == 0) || (c == start2_at) || (start_on_done && o_done);
      i_tx_full = full_pat[c];
      if (c == 0) i_pc = pc_val;
      else if (c == pc_chg_at) i_pc = 32'hFFFF_FFFF;
      if (c == rst_at) i_reset = 1'b0;
      #1;
      tr_wr[c] = o_tx_wr; tr_data[c] = o_tx_data; tr_busy[c] = o_busy;
      tr_done[c] = o_done; tr_addr[c] = o_addr; tr_sel[c] = o_sel;
    end
    @(negedge i_clk);
    i_start = 1'b0;
    i_tx_full = 1'b0;
    got.delete();
    for (int c = 0; c < ncyc; c++) if (tr_wr[c] === 1'b1) got.push_back(tr_data[c]);
  endtask

  task automatic test_reset();
    i_reset = 1'b0;
    repeat (3) @(negedge i_clk);
    #1;
    total++; if (o_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", o_addr); end
    total++; if (o_sel !== 1'b0) begin bad++; $display("FAIL rst_sel got=%b exp=0", o_sel); end
    total++; if (o_tx_data !== 8'h00) begin bad++; $display("FAIL rst_data got=%h exp=00", o_tx_data); end
    total++; if (o_tx_wr !== 1'b0) begin bad++; $display("FAIL rst_wr got=%b exp=0", o_tx_wr); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", o_busy); end
    total++; if (o_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", o_done); end
    @(negedge i_clk);
    i_reset = 1'b1;
    repeat (2) @(negedge i_clk);
  endtask

  task automatic test_basic();
    logic [7:0] lit13 [13];
    logic [7:0] lit4 [4];
    int done_c;
    lit13 = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00,
              8'h01, 8'h01, 8'h01, 8'h01};
    lit4  = '{8'hDE, 8'hAD, 8'h00, 8'h1F};
    clear_cfg(); fixed_data(); pc_val = 32'h0000_0040;
    build_expect(400); build_bytes(pc_val);
    drive_frame(400);
    done_c = -1;
    for (int c = 0; c < 400; c++) begin
      if (tr_done[c] === 1'b1 && done_c < 0) done_c = c;
      total++; if (tr_wr[c] !== ex_wr[c]) begin bad++; $display("FAIL basic_wr c=%0d got=%b exp=%b", c, tr_wr[c], ex_wr[c]); end
      total++; if (tr_busy[c] !== ex_busy[c]) begin bad++; $display("FAIL basic_busy c=%0d got=%b exp=%b", c, tr_busy[c], ex_busy[c]); end
    end
    total++; if (got.size() != NBYTES) begin bad++; $display("FAIL basic_count got=%0d exp=%0d", got.size(), NBYTES); end
    for (int i = 0; i < 13 && i < got.size(); i++) begin
      total++; if (got[i] !== lit13[i]) begin bad++; $display("FAIL basic_head i=%0d got=%h exp=%h", i, got[i], lit13[i]); end
    end
    for (int i = 0; i < 4 && got.size() == NBYTES; i++) begin
      total++; if (got[NBYTES - 4 + i] !== lit4[i]) begin bad++; $display("FAIL basic_tail i=%0d got=%h exp=%h", i, got[NBYTES - 4 + i], lit4[i]); end
    end
    for (int i = 0; i < NBYTES && i < got.size(); i++) begin
      total++; if (got[i] !== ex_bytes[i]) begin bad++; $display("FAIL basic_byte i=%0d got=%h exp=%h", i, got[i], ex_bytes[i]); end
    end
    total++; if (done_c != 390) begin bad++; $display("FAIL basic_done_cycle got=%0d exp=390", done_c); end
  endtask

  task automatic test_backpressure();
    int done_c;
    clear_cfg(); fixed_data(); pc_val = 32'h0000_0040;
    full_pat[3] = 1'b1; full_pat[4] = 1'b1; full_pat[5] = 1'b1;
    for (int c = 6; c < MAXC; c++) full_pat[c] = ($urandom_range(99) < 30);
    build_expect(MAXC); build_bytes(pc_val);
    drive_frame(MAXC);
    total++; if (ex_end < 0) begin bad++; $display("FAIL bp_timeout got=%0d exp=done_within_budget", ex_end); end
    done_c = -1;
    for (int c = 0; c < MAXC; c++) begin
      if (tr_done[c] === 1'b1 && done_c < 0) done_c = c;
      total++; if (tr_wr[c] !== ex_wr[c]) begin bad++; $display("FAIL bp_wr c=%0d got=%b exp=%b", c, tr_wr[c], ex_wr[c]); end
      if (ex_slot[c] >= 0 && is_send(ex_slot[c])) begin
        total++;
        if (tr_data[c] !== ex_bytes[byte_of_slot(ex_slot[c])]) begin
          bad++; $display("FAIL bp_data_hold c=%0d got=%h exp=%h", c, tr_data[c], ex_bytes[byte_of_slot(ex_slot[c])]);
        end
      end
    end
    total++; if (got.size() != NBYTES) begin bad++; $display("FAIL bp_count got=%0d exp=%0d", got.size(), NBYTES); end
    for (int i = 0; i < NBYTES && i < got.size(); i++) begin
      total++; if (got[i] !== ex_bytes[i]) begin bad++; $display("FAIL bp_byte i=%0d got=%h exp=%h", i, got[i], ex_bytes[i]); end
    end
    total++; if (done_c != 390 + ex_stalls) begin bad++; $display("FAIL bp_done_cycle got=%0d exp=%0d", done_c, 390 + ex_stalls); end
  endtask

  task automatic test_addr_sel();
    int k;
    clear_cfg(); rand_data(); pc_val = $urandom;
    build_expect(400); build_bytes(pc_val);
    drive_frame(400);
    for (int c = 0; c < 400; c++) begin
      if (ex_slot[c] >= 5 && ex_slot[c] < SLOTS - 1) begin
        k = (ex_slot[c] - 5) / 6;
        total++; if (tr_addr[c] !== 32'(k % NW)) begin bad++; $display("FAIL addr c=%0d got=%h exp=%h", c, tr_addr[c], k % NW); end
        total++; if (tr_sel[c] !== (k >= NW)) begin bad++; $display("FAIL sel c=%0d got=%b exp=%b", c, tr_sel[c], k >= NW); end
      end
    end
    total++; if (got.size() != NBYTES) begin bad++; $display("FAIL addr_count got=%0d exp=%0d", got.size(), NBYTES); end
    for (int i = 0; i < NBYTES && i < got.size(); i++) begin
      total++; if (got[i] !== ex_bytes[i]) begin bad++; $display("FAIL addr_byte i=%0d got=%h exp=%h", i, got[i], ex_bytes[i]); end
    end
  endtask

  task automatic test_start_while_busy();
    int ndone;
    clear_cfg(); rand_data(); pc_val = $urandom;
    start2_at = 100; start_on_done = 1'b1;
    build_expect(460); build_bytes(pc_val);
    drive_frame(460);
    ndone = 0;
    for (int c = 0; c < 460; c++) begin
      if (tr_done[c] === 1'b1) ndone++;
      total++; if (tr_busy[c] !== ex_busy[c]) begin bad++; $display("FAIL busy_start_busy c=%0d got=%b exp=%b", c, tr_busy[c], ex_busy[c]); end
      total++; if (tr_wr[c] !== ex_wr[c]) begin bad++; $display("FAIL busy_start_wr c=%0d got=%b exp=%b", c, tr_wr[c], ex_wr[c]); end
    end
    total++; if (ndone != 1) begin bad++; $display("FAIL busy_start_dones got=%0d exp=1", ndone); end
    total++; if (got.size() != NBYTES) begin bad++; $display("FAIL busy_start_count got=%0d exp=%0d", got.size(), NBYTES); end
    for (int i = 0; i < NBYTES && i < got.size(); i++) begin
      total++; if (got[i] !== ex_bytes[i]) begin bad++; $display("FAIL busy_start_byte i=%0d got=%h exp=%h", i, got[i], ex_bytes[i]); end
    end
  endtask

  task automatic test_reset_mid();
    clear_cfg(); rand_data(); pc_val = $urandom;
    rst_at = 150;
    drive_frame(153);
    for (int c = 150; c < 153; c++) begin
      total++; if (tr_wr[c] !== 1'b0) begin bad++; $display("FAIL rmid_wr c=%0d got=%b exp=0", c, tr_wr[c]); end
      total++; if (tr_busy[c] !== 1'b0) begin bad++; $display("FAIL rmid_busy c=%0d got=%b exp=0", c, tr_busy[c]); end
    end
    i_reset = 1'b1;
    repeat (3) @(negedge i_clk);
    #1;
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL rmid_idle_busy got=%b exp=0", o_busy); end
    clear_cfg(); rand_data(); pc_val = $urandom;
    build_expect(400); build_bytes(pc_val);
    drive_frame(400);
    total++; if (got.size() != NBYTES) begin bad++; $display("FAIL rmid_count got=%0d exp=%0d", got.size(), NBYTES); end
    total++; if (got.size() > 0 && got[0] !== 8'hA5) begin bad++; $display("FAIL rmid_first got=%h exp=a5", got[0]); end
    for (int i = 0; i < NBYTES && i < got.size(); i++) begin
      total++; if (got[i] !== ex_bytes[i]) begin bad++; $display("FAIL rmid_byte i=%0d got=%h exp=%h", i, got[i], ex_bytes[i]); end
    end
  endtask

  task automatic test_pc_snapshot();
    clear_cfg(); rand_data(); pc_val = $urandom & 32'h7FFF_FFFF;
    pc_chg_at = 1;
    build_expect(400); build_bytes(pc_val);
    drive_frame(400);
    total++; if (got.size() != NBYTES) begin bad++; $display("FAIL pc_count got=%0d exp=%0d", got.size(), NBYTES); end
    for (int i = 1; i < 5 && i < got.size(); i++) begin
      total++; if (got[i] !== pc_val[39 - 8 * i -: 8]) begin bad++; $display("FAIL pc_byte i=%0d got=%h exp=%h", i, got[i], pc_val[39 - 8 * i -: 8]); end
    end
    for (int i = 5; i < NBYTES && i < got.size(); i++) begin
      total++; if (got[i] !== ex_bytes[i]) begin bad++; $display("FAIL pc_word_byte i=%0d got=%h exp=%h", i, got[i], ex_bytes[i]); end
    end
  endtask

  initial begin
    for (int i = 0; i < NW; i++) begin regs[i] = '0; mems[i] = '0; end
    clear_cfg();
    test_reset();
    test_basic();
    repeat (3) @(negedge i_clk);
    test_backpressure();
    repeat (3) @(negedge i_clk);
    test_addr_sel();
    repeat (3) @(negedge i_clk);
    test_start_while_busy();
    repeat (3) @(negedge i_clk);
    test_reset_mid();
    repeat (3) @(negedge i_clk);
    test_pc_snapshot();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/debug_dump_tx.md
# debug_dump_tx

Transmit-side sequencer of the debug unit. The receive side loads instructions into the pipeline; this block streams the processor state back to the host as one byte-serial dump frame. On a start pulse it snapshots the PC, walks the register file and the data memory through a shared read address bus, and pushes every word MSB-first into the UART transmit FIFO, honouring FIFO back-pressure.

## Interface
- NB_REG, 32: word width of PC, registers, data memory and o_addr
- N_REGS, 32: register-file words dumped
- N_MEM_WORDS, 32: data-memory words dumped (word addresses 0..N_MEM_WORDS-1)
- HDR_BYTE, 8'hA5: frame header byte

Ports:
- i_clk, in, 1: single clock; all state on rising edge
- i_reset, in, 1: reset, asynchronous, active-low
- i_start, in, 1: one-cycle request to begin a dump; ignored while o_busy=1
- i_pc, in, NB_REG: current PC; sampled only in the i_start cycle
- i_reg_data, in, NB_REG: register-file read data, valid the cycle after o_addr is presented with o_sel=0
- i_mem_data, in, NB_REG: data-memory read data, valid the cycle after o_addr is presented with o_sel=1
- i_tx_full, in, 1: TX FIFO full
- o_addr, out, NB_REG: read address (register index or memory word index)
- o_sel, out, 1: 0 = register file section, 1 = data memory section
- o_tx_data, out, 8: byte to the TX FIFO
- o_tx_wr, out, 1: write strobe; a byte is accepted in every cycle with o_tx_wr=1
- o_busy, out, 1: high from the cycle after an accepted i_start until the end of the frame
- o_done, out, 1: one-cycle pulse at the end of the frame

## Operation
- Frame order: HDR_BYTE; PC (4 bytes); reg[0..N_REGS-1]; mem[0..N_MEM_WORDS-1]. Each word is sent MSB byte first. Default frame is 261 bytes.
- States:
  - IDLE: on i_start, latch i_pc into a shift register and go to HDR.
  - HDR: send HDR_BYTE, then go to PC.
  - PC: send 4 bytes, then go to FETCH with o_sel=0 and index=0.
  - FETCH: drive o_addr=index, then go to LATCH.
  - LATCH: load the selected data input into the 32-bit shift register, then go to WORD.
  - WORD: send 4 bytes. When the section's last index is done, advance to the next section, or go to DONE after the memory section. Otherwise increment index and go to FETCH.
  - DONE: pulse o_done, then go to IDLE.
- o_addr is held from FETCH through the end of WORD. Its upper bits are zero.
- Send states use o_tx_wr = ~i_tx_full (combinational). The byte counter and shift register advance only when o_tx_wr=1. While i_tx_full=1, o_tx_data is held stable.
- The section index wraps to 0 when switching from registers to memory. The index counter is wide enough for max(N_REGS, N_MEM_WORDS).
- A new i_start during a frame (o_busy=1) is ignored and not queued. i_start in the DONE cycle is also ignored.
- i_pc changes after the start cycle do not affect the frame.

## Timing
- Reset values: o_addr=0, o_sel=0, o_tx_data=0, o_tx_wr=0, o_busy=0, o_done=0; state is IDLE.
- Asserting reset mid-frame forces IDLE and drops o_tx_wr/o_busy asynchronously. No partial frame resumes after release.
- With i_tx_full=0 throughout and i_start in cycle 0:
  - HDR write in cycle 1.
  - PC bytes in cycles 2-5.
  - Word k (0-based over all 64 words) has FETCH in 6+6k, LATCH in 7+6k, and byte writes in 8+6k .. 11+6k.
  - o_done in cycle 390; o_busy high in cycles 1-390, low from 391.
- Each full cycle adds exactly one cycle of stall to the remaining schedule. No byte is dropped or duplicated.

## Test plan
- Basic frame: i_pc=0x0000_0040, reg[i]=i*0x0101_0101, mem[j]=0xDEAD_0000+j, never full, i_start at cycle 0. Required: exactly 261 writes, beginning A5 00 00 00 40 00 00 00 00 01 01 01 01, last four bytes DE AD 00 1F; o_done in cycle 390.
- Back-pressure: same frame with i_tx_full high for 3 cycles during the second PC byte and randomly at 30% afterwards. Required: identical byte stream, o_tx_data stable while full, o_done delayed by exactly the number of stalled send cycles.
- Address/sel check: o_addr runs 0..31 with o_sel=0, then 0..31 with o_sel=1, each value held for 6 cycles when unstalled. Data sampled in LATCH equals the memory model's read of the previous cycle's address.
- Start while busy: second i_start at cycle 100, plus one coincident with o_done. Required: single frame, 261 bytes, no second frame.
- Reset mid-frame: drive i_reset low at cycle 150. Required: o_tx_wr=0 and o_busy=0 immediately. After release and a new i_start, a complete fresh 261-byte frame is sent, starting with A5.
- PC snapshot: i_pc changes to 0xFFFF_FFFF at cycle 1. Required: PC bytes still show the value sampled at i_start.
